// File: rtl/led_seq_arb.sv
// ---------------------------------------------------------------------------
// led_seq_arb
//
// Shares one LED between four requesters. A winner is chosen from the
// request vector. The winner's 4-bit blink count is latched, and the LED
// blinks that many times. Each blink is HALF_PERIOD cycles on followed by
// HALF_PERIOD cycles off. After the last blink the LED stays off for
// GAP_CYCLES cycles. The block then returns to idle and pulses done.
//
// A latched count of 0 is a null sequence. Grant is held for one cycle, the
// LED stays off, no gap is inserted, and the block returns to idle with done.
//
// Arbitration is round-robin by default. The search starts at the requester
// after the last granted one, and the pointer resets to requester 0.
// Defining LED_SEQ_ARB_FIXED_PRIO_EN selects fixed priority instead
// (req[0] highest) and removes the pointer.
//
// Parameters:
//   HALF_PERIOD  cycles per LED on-phase and per off-phase (>= 1)
//   GAP_CYCLES   cycles of LED-off gap after the final blink (>= 1)
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-low reset
//   req[3:0]   in   level requests, bit i = requester i
//   blink_cnt  in   [4i+3:4i] = blink count of requester i
//   led        out  shared LED drive, 1 = on
//   grant[3:0] out  one-hot owner of the running sequence, 0 when idle
//   busy       out  high whenever the FSM is not idle
//   done       out  one-cycle pulse when a sequence ends
//
// Request handshake: req is a level. It is sampled only while idle.
// Changes on req and blink_cnt are ignored while busy, and dropping req
// does not abort a running sequence.
// ---------------------------------------------------------------------------
module led_seq_arb #(
    parameter int HALF_PERIOD = 50_000_000,
    parameter int GAP_CYCLES  = 200_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] blink_cnt,
    output logic        led,
    output logic [3:0]  grant,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam logic [31:0] HP_LAST  = 32'(HALF_PERIOD - 1);
    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);

    state_t      r_state;
    logic [31:0] r_phase;   // cycle count within the current phase
    logic [3:0]  r_blink;   // blinks remaining, including the current one

    logic        w_any;
    logic [1:0]  w_win;
    logic [3:0]  w_cnt;

    assign w_any = |req;

`ifdef LED_SEQ_ARB_FIXED_PRIO_EN
    // Scan from the lowest priority up, so the highest-priority hit wins last.
    always_comb begin
        w_win = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req[k]) w_win = 2'(k);
        end
    end
`else
    logic [1:0] r_ptr;   // first requester searched on the next arbitration
    logic [1:0] w_idx;

    // Scan the search order backwards, so the first hit after r_ptr wins.
    always_comb begin
        w_win = r_ptr;
        w_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (req[w_idx]) w_win = w_idx;
        end
    end
`endif

    assign w_cnt = blink_cnt[{w_win, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_blink <= '0;
            led     <= 1'b0;
            grant   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifndef LED_SEQ_ARB_FIXED_PRIO_EN
            r_ptr   <= 2'd0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        grant <= 4'(4'b0001 << w_win);
                        busy  <= 1'b1;
`ifndef LED_SEQ_ARB_FIXED_PRIO_EN
                        r_ptr <= w_win + 2'd1;
`endif
                        if (w_cnt == 4'd0) begin
                            // Null sequence: enter OFF at its last cycle with
                            // no blinks left, so it exits to idle next edge.
                            r_state <= S_OFF;
                            r_phase <= HP_LAST;
                            r_blink <= 4'd0;
                            led     <= 1'b0;
                        end else begin
                            r_state <= S_ON;
                            r_phase <= '0;
                            r_blink <= w_cnt;
                            led     <= 1'b1;
                        end
                    end
                end
                S_ON: begin
                    if (r_phase == HP_LAST) begin
                        r_state <= S_OFF;
                        r_phase <= '0;
                        led     <= 1'b0;
                    end else begin
                        r_phase <= r_phase + 32'd1;
                    end
                end
                S_OFF: begin
                    if (r_phase == HP_LAST) begin
                        r_phase <= '0;
                        if (r_blink == 4'd0) begin
                            r_state <= S_IDLE;
                            grant   <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else if (r_blink == 4'd1) begin
                            r_state <= S_GAP;
                            r_blink <= 4'd0;
                        end else begin
                            r_state <= S_ON;
                            r_blink <= r_blink - 4'd1;
                            led     <= 1'b1;
                        end
                    end else begin
                        r_phase <= r_phase + 32'd1;
                    end
                end
                S_GAP: begin
                    if (r_phase == GAP_LAST) begin
                        r_state <= S_IDLE;
                        r_phase <= '0;
                        grant   <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_phase <= r_phase + 32'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/led_seq_arb.md
LED_SEQ_ARB -- requirements
Module: led_seq_arb

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 50_000_000, cycles per LED on-phase and per off-phase (>=1).
REQ-002 SHALL have parameter GAP_CYCLES, default 200_000_000, cycles of LED-off gap after the last blink of a sequence (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req  input  4  per-requester level request; bit i is requester i.
REQ-006 SHALL have port blink_cnt  input  16  blink count per requester, 4 bits each, [4i+3:4i] belongs to requester i.
REQ-007 SHALL have port led  output  1  shared LED drive, 1 = on.
REQ-008 SHALL have port grant  output  4  one-hot owner of the current sequence, 0 when idle.
REQ-009 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-010 SHALL have port done  output  1  single-cycle pulse at the end of each sequence.

Function
REQ-011 SHALL implement FSM states IDLE, ON, OFF and GAP.
REQ-012 SHALL, in IDLE with any req bit set, select a winner on the next edge, set grant to the winner's one-hot code, latch its blink_cnt and go to ON with led=1.
- REQ-012 latency: req high at edge k gives grant and led at edge k+1.
REQ-013 SHALL keep led=1 for exactly HALF_PERIOD cycles in ON, then led=0 for exactly HALF_PERIOD cycles in OFF; each ON+OFF pair is one blink.
REQ-014 SHALL, after OFF of the final blink, enter GAP with led=0 for exactly GAP_CYCLES cycles.
REQ-015 SHALL, on GAP expiry, return to IDLE, clear grant and pulse done high for exactly one cycle.
- REQ-015 total: grant rise to done rise = 2*HALF_PERIOD*N + GAP_CYCLES cycles, where N is the latched count.
REQ-016 SHALL use round-robin arbitration: the search starts at the requester after the last granted one, and the pointer starts at requester 0 after reset.
REQ-017 SHALL treat a latched count of 0 as a null sequence: grant held for one cycle, led stays 0, no GAP, then IDLE with done pulsed.
REQ-018 SHALL ignore changes on req and blink_cnt while busy; a deasserted req does not abort the sequence.
REQ-019 SHALL leave at least one IDLE cycle, coincident with done, between consecutive sequences.
REQ-020 SHALL use 32-bit phase counters and 4-bit blink counters, with no wrap-around within a phase.

Reset
REQ-021 SHALL, with rst=0 at a rising edge, force IDLE, led=0, grant=0, busy=0, done=0, all counters to 0 and the RR pointer to requester 0; this includes reset mid-sequence.
REQ-022 SHALL hold all outputs at their reset values while rst=0, and start no sequence until the first edge with rst=1.

Configuration
REQ-023 SHALL, when macro LED_SEQ_ARB_FIXED_PRIO_EN is defined, replace round-robin with fixed priority (req[0] highest, req[3] lowest) and omit the RR pointer.
REQ-024 SHALL, without LED_SEQ_ARB_FIXED_PRIO_EN, use round-robin per REQ-016.

Verification (HALF_PERIOD=4, GAP_CYCLES=8)
REQ-025 SHALL cover a single request: req=4'b0010 with count 3 -> grant=4'b0010 next cycle, led pattern 4 on/4 off x3, 8 off, done at cycle 32 after grant.
REQ-026 SHALL cover round-robin: req=4'b1111 held, counts 1 -> grants in order 0001, 0010, 0100, 1000, 0001, each 16 cycles long, with one idle cycle between.
REQ-027 SHALL cover a null sequence: req=4'b0100 with count 0 -> grant=4'b0100 for 1 cycle, led never high, done on the following cycle.
REQ-028 SHALL cover reset mid-sequence: rst=0 in the second ON phase -> next edge led=0, grant=0, busy=0, and a later req=4'b1000 is granted as if fresh.
REQ-029 SHALL cover request withdrawal: req=4'b0001 with count 2, req dropped after 1 cycle -> full 24-cycle sequence and done still produced.
REQ-030 SHALL cover fixed priority with the macro defined: req=4'b1010 held, counts 1 -> grant=4'b0010 repeatedly, requester 3 never granted.
